fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have parameter DEPTH, default 2, instruction buffer entries (power of two, >=2).
REQ-003 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have port stall  in  1  decode-register hold (StallFetch); 1 = head entry not consumed.
REQ-006 SHALL have port redirect  in  1  taken branch/jump from execute (PCSrcE).
REQ-007 SHALL have port pcTarget  in  32  redirect address.
REQ-008 SHALL have port imem_req_valid  out  1  fetch request valid.
REQ-009 SHALL have port imem_req_ready  in  1  memory accepts request.
REQ-010 SHALL have port imem_addr  out  32  fetch address.
REQ-011 SHALL have port imem_rsp_valid  in  1  instruction word returned (in order, >=1 cycle after acceptance).
REQ-012 SHALL have port imem_rsp_data  in  32  returned instruction.
REQ-013 SHALL have ports pcF, pcPlus4F, instrF  out  32 each  head entry to the decode register.
REQ-014 SHALL have port validF  out  1  head entry valid.

Function
REQ-015 SHALL keep a request PC (reqPC), a response PC (rspPC), an outstanding counter (0..DEPTH), a drop counter (0..DEPTH) and a DEPTH-entry FIFO of {pc, instr}.
REQ-016 SHALL drive imem_req_valid = !redirect && (outstanding + fifoCount < DEPTH); imem_addr = reqPC.
REQ-017 SHALL, on handshake (valid && ready), advance reqPC by 4 (mod 2^32 wrap) and increment outstanding.
REQ-018 SHALL, on imem_rsp_valid with outstanding > 0, decrement outstanding; simultaneous accept and response leave outstanding unchanged.
REQ-019 SHALL, on a response with drop counter = 0, push {rspPC, imem_rsp_data} and advance rspPC by 4; with drop counter > 0, discard data and decrement drop counter.
REQ-020 SHALL ignore imem_rsp_valid when outstanding = 0 (protocol error, no state change).
REQ-021 SHALL drive validF = FIFO non-empty; pcF/instrF = head fields; pcPlus4F = pcF + 4.
REQ-022 SHALL output pcF = pcPlus4F = instrF = 32'h0 when validF = 0 (decode register treats zero as NOP).
REQ-023 SHALL pop the head when validF && !stall; push and pop in one cycle keep count unchanged.
REQ-024 SHALL never overflow the FIFO (guaranteed by REQ-016 credit rule); a push while full is a design error.
REQ-025 SHALL, on redirect: set reqPC = rspPC = pcTarget, empty the FIFO, set drop counter = outstanding after this cycle's response (a response arriving in the redirect cycle is itself discarded), issue no request that cycle.
REQ-026 SHALL give redirect priority over stall, pop and push in the same cycle.
REQ-027 SHALL have latency: redirect at edge N -> request for pcTarget visible from cycle N+1; response at edge M -> validF from cycle M+1 (FIFO previously empty).

Reset
REQ-028 SHALL, while rst_n = 0, asynchronously set reqPC = rspPC = RESET_PC, outstanding = drop = 0, FIFO empty, so validF = 0 and pcF/pcPlus4F/instrF = 0.
REQ-029 SHALL discard all in-flight fetches on reset; responses to pre-reset requests are treated per REQ-020.
REQ-030 SHALL drive imem_req_valid = 1 with imem_addr = RESET_PC in the first cycle after rst_n deasserts (memory ready).

Verification
REQ-031 Reset release, ready=1, 1-cycle memory, stall=0 -> addresses 0,4,8,... issued; validF from cycle 2 with pcF=0, instrF = mem[0], pcPlus4F=4.
REQ-032 stall=1 for 5 cycles -> FIFO fills to 2, imem_req_valid=0, head stays pcF=0x8; on release sequence resumes with no gap or duplicate.
REQ-033 redirect with pcTarget=0x100 while 2 responses outstanding -> both discarded, FIFO empty next cycle, next validF shows pcF=0x100.
REQ-034 imem_req_ready=0 for 3 cycles -> imem_addr held stable, no outstanding increment, validF drains to 0.
REQ-035 reqPC=0xFFFF_FFFC accepted -> next imem_addr = 0x0000_0000; pcPlus4F for that entry = 0x0.
REQ-036 rst_n asserted mid-stream (asynchronous, between edges) -> validF, outputs 0 immediately; stray response after release ignored, first fetch = RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: decoupled instruction fetch with a small in-order buffer.
// Requests are credit-limited so every response has a free buffer slot.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] pcTarget,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [31:0] pcF,
  output logic [31:0] pcPlus4F,
  output logic [31:0] instrF,
  output logic        validF
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

  logic [31:0]   reqPC;
  logic [31:0]   rspPC;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [CW-1:0] count;
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];

  logic [CW:0] credit;
  logic        req_fire;
  logic        rsp_ok;
  logic        push;
  logic        pop;

  // Responses still in flight hold a slot just like buffered entries.
  assign credit = {1'b0, outstanding} + {1'b0, count};

  assign imem_req_valid = !redirect && (credit < LIMIT);
  assign imem_addr      = reqPC;

  assign req_fire = imem_req_valid && imem_req_ready;
  assign rsp_ok   = imem_rsp_valid && (outstanding != '0);
  assign push     = rsp_ok && (drop == '0) && !redirect;

  assign validF = (count != '0);
  assign pop    = validF && !stall && !redirect;

  // Head fields, forced to zero so an empty buffer reads as a NOP.
  always_comb begin
    pcF      = 32'h0;
    pcPlus4F = 32'h0;
    instrF   = 32'h0;
    if (validF) begin
      pcF      = pc_mem[rd_ptr];
      pcPlus4F = pc_mem[rd_ptr] + 32'd4;
      instrF   = instr_mem[rd_ptr];
    end
  end

  // Request and response PCs; a redirect restarts both streams.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reqPC <= RESET_PC;
      rspPC <= RESET_PC;
    end else if (redirect) begin
      reqPC <= pcTarget;
      rspPC <= pcTarget;
    end else begin
      if (req_fire) reqPC <= reqPC + 32'd4;
      if (push)     rspPC <= rspPC + 32'd4;
    end
  end

  // In-flight request count; accept and return together cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      unique case ({req_fire, rsp_ok})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  // Stale responses to skip; a response in the redirect cycle is already gone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop <= '0;
    end else if (redirect) begin
      drop <= outstanding - CW'(rsp_ok);
    end else if (rsp_ok && (drop != '0)) begin
      drop <= drop - CW'(1);
    end
  end

  // Buffer pointers and occupancy; a redirect flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (redirect) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Buffer storage needs no reset; occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr]    <= rspPC;
      instr_mem[wr_ptr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scenarios for fetch_stage.
// Memory model answers in order, one cycle after acceptance unless held.
module tb_fetch_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        redirect;
  logic [31:0] pcTarget;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic [31:0] instrF;
  logic        validF;

  bit          hold;
  bit          stray;
  logic [31:0] q[$];

  int          checks;
  int          errors;
  logic [31:0] exp_pc;

  fetch_stage #(.RESET_PC(32'h0), .DEPTH(2)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .stall(stall),
    .redirect(redirect),
    .pcTarget(pcTarget),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .pcF(pcF),
    .pcPlus4F(pcPlus4F),
    .instrF(instrF),
    .validF(validF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  always @(posedge clk) begin
    imem_rsp_valid <= 1'b0;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (imem_req_valid && imem_req_ready) q.push_back(imem_addr);
      if (!hold && q.size() > 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem(q.pop_front());
      end
    end
    if (stray) begin
      imem_rsp_valid <= 1'b1;
      imem_rsp_data  <= 32'hDEAD_BEEF;
    end
  end

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({validF, pcF, pcPlus4F, instrF} !== {1'b0, 96'h0}) begin
      errors++;
      $display("FAIL reset_out got v=%b pc=%h p4=%h in=%h exp all 0",
               validF, pcF, pcPlus4F, instrF);
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL first_req got v=%b a=%h exp v=1 a=0",
               imem_req_valid, imem_addr);
    end
  endtask

  task automatic test_stream();
    bit found;
    @(negedge clk);
    checks++;
    if ({validF, imem_addr} !== {1'b0, 32'h4}) begin
      errors++;
      $display("FAIL stream_c1 got v=%b a=%h exp v=0 a=4", validF, imem_addr);
    end
    @(negedge clk);
    checks++;
    if ({validF, pcF, instrF, pcPlus4F} !==
        {1'b1, 32'h0, mem(32'h0), 32'h4}) begin
      errors++;
      $display("FAIL stream_c2 got v=%b pc=%h in=%h p4=%h exp v=1 pc=0 in=%h p4=4",
               validF, pcF, instrF, pcPlus4F, mem(32'h0));
    end
    exp_pc = 32'h4;
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (validF && pcF == 32'h8) begin
        found = 1;
      end else if (validF) begin
        checks++;
        if ({pcF, instrF, pcPlus4F} !== {exp_pc, mem(exp_pc), exp_pc + 32'd4}) begin
          errors++;
          $display("FAIL stream_seq got pc=%h in=%h p4=%h exp pc=%h",
                   pcF, instrF, pcPlus4F, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL stream_reach8 got timeout exp head pc=8");
    end
    exp_pc = 32'h8;
  endtask

  task automatic test_stall();
    int pops;
    stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if ({validF, pcF, imem_req_valid} !== {1'b1, 32'h8, 1'b0}) begin
        errors++;
        $display("FAIL stall_hold got v=%b pc=%h rv=%b exp v=1 pc=8 rv=0",
                 validF, pcF, imem_req_valid);
      end
    end
    stall = 1'b0;
    exp_pc = 32'h8;
    @(negedge clk);
    checks++;
    if ({validF, pcF} !== {1'b1, 32'hC}) begin
      errors++;
      $display("FAIL stall_full got v=%b pc=%h exp v=1 pc=c", validF, pcF);
    end
    exp_pc = 32'h10;
    pops = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (validF) begin
        pops++;
        checks++;
        if ({pcF, instrF, pcPlus4F} !== {exp_pc, mem(exp_pc), exp_pc + 32'd4}) begin
          errors++;
          $display("FAIL stall_seq got pc=%h in=%h p4=%h exp pc=%h",
                   pcF, instrF, pcPlus4F, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (pops < 3) begin
      errors++;
      $display("FAIL stall_resume got pops=%0d exp >=3", pops);
    end
  endtask

  task automatic test_ready();
    bit found;
    logic [31:0] a;
    int pops;
    found = 0;
    a = '0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (validF) begin
        checks++;
        if ({pcF, instrF} !== {exp_pc, mem(exp_pc)}) begin
          errors++;
          $display("FAIL ready_pre got pc=%h exp %h", pcF, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req_valid) begin
        found = 1;
        a = imem_addr;
        imem_req_ready = 1'b0;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ready_find got timeout exp imem_req_valid=1");
    end
    repeat (3) begin
      @(negedge clk);
      if (validF) begin
        checks++;
        if ({pcF, instrF} !== {exp_pc, mem(exp_pc)}) begin
          errors++;
          $display("FAIL ready_drain got pc=%h exp %h", pcF, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
      checks++;
      if (imem_addr !== a) begin
        errors++;
        $display("FAIL ready_addr got %h exp %h", imem_addr, a);
      end
    end
    checks++;
    if (validF !== 1'b0) begin
      errors++;
      $display("FAIL ready_empty got v=%b exp 0", validF);
    end
    imem_req_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (validF) begin
        pops++;
        checks++;
        if ({pcF, instrF, pcPlus4F} !== {exp_pc, mem(exp_pc), exp_pc + 32'd4}) begin
          errors++;
          $display("FAIL ready_seq got pc=%h in=%h exp pc=%h", pcF, instrF, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
      end
    end
    checks++;
    if (pops < 2) begin
      errors++;
      $display("FAIL ready_resume got pops=%0d exp >=2", pops);
    end
  endtask

  task automatic test_redirect();
    bit found;
    @(negedge clk);
    rst_n = 1'b0;
    hold = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h4}) begin
      errors++;
      $display("FAIL redir_n1 got rv=%b a=%h exp rv=1 a=4", imem_req_valid, imem_addr);
    end
    @(negedge clk);
    checks++;
    if (imem_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL redir_credit got rv=%b exp 0", imem_req_valid);
    end
    redirect = 1'b1;
    pcTarget = 32'h100;
    hold = 1'b0;
    @(negedge clk);
    checks++;
    if ({validF, imem_addr} !== {1'b0, 32'h100}) begin
      errors++;
      $display("FAIL redir_n3 got v=%b a=%h exp v=0 a=100", validF, imem_addr);
    end
    redirect = 1'b0;
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (validF) begin
        found = 1;
        checks++;
        if ({pcF, instrF} !== {32'h100, mem(32'h100)}) begin
          errors++;
          $display("FAIL redir_first got pc=%h in=%h exp pc=100 in=%h",
                   pcF, instrF, mem(32'h100));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir_timeout got no valid exp pc=100");
    end
    stall = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({validF, pcF, imem_req_valid} !== {1'b1, 32'h100, 1'b0}) begin
      errors++;
      $display("FAIL redir_fill got v=%b pc=%h rv=%b exp v=1 pc=100 rv=0",
               validF, pcF, imem_req_valid);
    end
    redirect = 1'b1;
    pcTarget = 32'h200;
    @(negedge clk);
    checks++;
    if ({validF, pcF, instrF, pcPlus4F, imem_addr} !== {1'b0, 96'h0, 32'h200}) begin
      errors++;
      $display("FAIL redir_flush got v=%b pc=%h in=%h p4=%h a=%h exp 0,0,0,0,200",
               validF, pcF, instrF, pcPlus4F, imem_addr);
    end
    redirect = 1'b0;
    stall = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1) begin
      errors++;
      $display("FAIL redir_req got rv=%b exp 1", imem_req_valid);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (validF) begin
        found = 1;
        checks++;
        if ({pcF, instrF} !== {32'h200, mem(32'h200)}) begin
          errors++;
          $display("FAIL redir2_first got pc=%h in=%h exp pc=200", pcF, instrF);
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL redir2_timeout got no valid exp pc=200");
    end
  endtask

  task automatic test_wrap();
    bit seen;
    bit wrapchk;
    int pops;
    redirect = 1'b1;
    pcTarget = 32'hFFFF_FFFC;
    @(negedge clk);
    checks++;
    if (validF !== 1'b0) begin
      errors++;
      $display("FAIL wrap_flush got v=%b exp 0", validF);
    end
    redirect = 1'b0;
    #1;
    seen = imem_req_valid && (imem_addr == 32'hFFFF_FFFC);
    wrapchk = 0;
    exp_pc = 32'hFFFF_FFFC;
    pops = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (seen && !wrapchk) begin
        wrapchk = 1;
        checks++;
        if (imem_addr !== 32'h0) begin
          errors++;
          $display("FAIL wrap_addr got %h exp 00000000", imem_addr);
        end
      end
      if (validF) begin
        pops++;
        checks++;
        if ({pcF, instrF, pcPlus4F} !== {exp_pc, mem(exp_pc), exp_pc + 32'd4}) begin
          errors++;
          $display("FAIL wrap_seq got pc=%h in=%h p4=%h exp pc=%h p4=%h",
                   pcF, instrF, pcPlus4F, exp_pc, exp_pc + 32'd4);
        end
        exp_pc = exp_pc + 32'd4;
      end
      if (imem_req_valid && imem_addr == 32'hFFFF_FFFC) seen = 1;
    end
    checks++;
    if (!wrapchk || pops < 3) begin
      errors++;
      $display("FAIL wrap_progress got seen=%b pops=%0d exp seen=1 pops>=3",
               wrapchk, pops);
    end
  endtask

  task automatic test_async_reset();
    bit found;
    stall = 1'b1;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2;
    checks++;
    if (validF !== 1'b1) begin
      errors++;
      $display("FAIL arst_pre got v=%b exp 1", validF);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({validF, pcF, pcPlus4F, instrF, imem_addr} !== {1'b0, 128'h0}) begin
      errors++;
      $display("FAIL arst_out got v=%b pc=%h p4=%h in=%h a=%h exp all 0",
               validF, pcF, pcPlus4F, instrF, imem_addr);
    end
    stall = 1'b0;
    stray = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    stray = 1'b0;
    #1;
    checks++;
    if ({imem_req_valid, imem_addr} !== {1'b1, 32'h0}) begin
      errors++;
      $display("FAIL arst_req got rv=%b a=%h exp rv=1 a=0", imem_req_valid, imem_addr);
    end
    found = 0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (validF) begin
        found = 1;
        checks++;
        if ({pcF, instrF, pcPlus4F} !== {32'h0, mem(32'h0), 32'h4}) begin
          errors++;
          $display("FAIL arst_first got pc=%h in=%h p4=%h exp pc=0 in=%h p4=4",
                   pcF, instrF, pcPlus4F, mem(32'h0));
        end
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL arst_timeout got no valid exp pc=0");
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_pc = '0;
    hold = 0;
    stray = 0;
    stall = 1'b0;
    redirect = 1'b0;
    pcTarget = 32'h0;
    imem_req_ready = 1'b1;
    rst_n = 1'b1;
    test_reset();
    test_stream();
    test_stall();
    test_ready();
    test_redirect();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
